// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Per-thread memory access engine. It answers the core scheduler's
// REQUEST / WAIT / UPDATE phases by issuing exactly one data-memory read (LDR)
// or write (STR) per instruction. It then reports progress on lsu_state so the
// scheduler can hold WAIT while any thread is still busy.
//
// Handshake semantics:
//   A request transfers on a rising edge where *_valid and *_ready are both 1.
//   While *_valid is 1, the address and data do not change. *_valid drops in
//   the cycle after the transfer. Responses (mem_read_rsp_valid,
//   mem_write_ack) are single-cycle pulses with no back-pressure. They are
//   only honoured in WAITING.
//
// Ports:
//   clk, reset                 core clock; synchronous active-high reset
//   enable                     thread active in this block
//   core_state[2:0]            scheduler phase (REQUEST=011, UPDATE=110)
//   decoded_mem_read_enable    instruction is LDR (wins if both are set)
//   decoded_mem_write_enable   instruction is STR
//   rs[DATA_BITS-1:0]          address operand
//   rt[DATA_BITS-1:0]          store data operand
//   mem_read_*                 read request / response channel
//   mem_write_*                write request / ack channel
//   lsu_state[1:0]             IDLE=00 REQUESTING=01 WAITING=10 DONE=11
//   lsu_out[DATA_BITS-1:0]     last load result
//   timeout_err                sticky; set when a transaction times out
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [DATA_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic                 mem_read_rsp_valid,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  input  logic                 mem_write_ack,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'b00,
    S_REQUESTING = 2'b01,
    S_WAITING    = 2'b10,
    S_DONE       = 2'b11
  } lsu_state_t;

  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;

  // The counter only needs to reach TIMEOUT_CYCLES-1. The edge that would
  // take it to TIMEOUT_CYCLES is the timeout edge itself.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TIMEOUT_ON = (TIMEOUT_CYCLES > 0);

  lsu_state_t       state;
  logic             is_read;
  logic [CNT_W-1:0] wait_cnt;
  logic [ADDR_BITS-1:0] rs_addr;
  logic             start;
  logic             timeout_hit;
  logic             handshake;

  // Address operand sized to the memory address width.
  generate
    if (ADDR_BITS <= DATA_BITS) begin : g_addr_trunc
      assign rs_addr = rs[ADDR_BITS-1:0];
    end else begin : g_addr_zext
      assign rs_addr = {{(ADDR_BITS-DATA_BITS){1'b0}}, rs};
    end
  endgenerate

  assign start = (core_state == CORE_REQUEST) && enable &&
                 (decoded_mem_read_enable || decoded_mem_write_enable);

  // A timeout edge takes priority over a handshake or response in the same
  // cycle, so the outcome depends only on how long the transaction has run.
  assign timeout_hit = TIMEOUT_ON && (wait_cnt == CNT_LAST);

  assign handshake = is_read ? (mem_read_valid  && mem_read_ready)
                             : (mem_write_valid && mem_write_ready);

  assign lsu_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      is_read           <= 1'b0;
      wait_cnt          <= '0;
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      lsu_out           <= '0;
      timeout_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_REQUESTING;
            wait_cnt <= '0;
            // A read wins when both enables are set.
            is_read  <= decoded_mem_read_enable;
            if (decoded_mem_read_enable) begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= rs_addr;
            end else begin
              mem_write_valid   <= 1'b1;
              mem_write_address <= rs_addr;
              mem_write_data    <= rt;
            end
          end
        end

        S_REQUESTING: begin
          if (timeout_hit) begin
            state           <= S_DONE;
            mem_read_valid  <= 1'b0;
            mem_write_valid <= 1'b0;
            lsu_out         <= '0;
            timeout_err     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (handshake) begin
              state           <= S_WAITING;
              mem_read_valid  <= 1'b0;
              mem_write_valid <= 1'b0;
            end
          end
        end

        S_WAITING: begin
          if (timeout_hit) begin
            state       <= S_DONE;
            lsu_out     <= '0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (is_read && mem_read_rsp_valid) begin
              lsu_out <= mem_read_data;
              state   <= S_DONE;
            end else if (!is_read && mem_write_ack) begin
              state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          if (core_state == CORE_UPDATE) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Bench for load_store_unit with TIMEOUT_CYCLES=8. Inputs are driven and
// outputs sampled on the falling edge. For each instruction, the reference
// model predicts the per-cycle lsu_state sequence from the ready/response
// delays and the timeout rule. It also predicts lsu_out and timeout_err.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [2:0]    core_state;
  logic          rd_en, wr_en;
  logic [DW-1:0] rs, rt;
  logic          mem_read_valid;
  logic [AW-1:0] mem_read_address;
  logic          mem_read_ready;
  logic          mem_read_rsp_valid;
  logic [DW-1:0] mem_read_data;
  logic          mem_write_valid;
  logic [AW-1:0] mem_write_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_write_ready;
  logic          mem_write_ack;
  logic [1:0]    lsu_state;
  logic [DW-1:0] lsu_out;
  logic          timeout_err;

  load_store_unit #(.ADDR_BITS(AW), .DATA_BITS(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .enable                   (enable),
    .core_state               (core_state),
    .decoded_mem_read_enable  (rd_en),
    .decoded_mem_write_enable (wr_en),
    .rs                       (rs),
    .rt                       (rt),
    .mem_read_valid           (mem_read_valid),
    .mem_read_address         (mem_read_address),
    .mem_read_ready           (mem_read_ready),
    .mem_read_rsp_valid       (mem_read_rsp_valid),
    .mem_read_data            (mem_read_data),
    .mem_write_valid          (mem_write_valid),
    .mem_write_address        (mem_write_address),
    .mem_write_data           (mem_write_data),
    .mem_write_ready          (mem_write_ready),
    .mem_write_ack            (mem_write_ack),
    .lsu_state                (lsu_state),
    .lsu_out                  (lsu_out),
    .timeout_err              (timeout_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [1:0]    exp_q[$];
  logic [DW-1:0] exp_out;
  logic          exp_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got=0x%0h expected=0x%0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic quiet_inputs();
    core_state         = 3'b000;
    enable             = 1'b0;
    rd_en              = 1'b0;
    wr_en              = 1'b0;
    mem_read_ready     = 1'b0;
    mem_read_rsp_valid = 1'b0;
    mem_read_data      = '0;
    mem_write_ready    = 1'b0;
    mem_write_ack      = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_state"},  lsu_state, 2'b00);
    chk({tag, "_rvalid"}, mem_read_valid, 1'b0);
    chk({tag, "_wvalid"}, mem_write_valid, 1'b0);
    chk({tag, "_out"},    lsu_out, exp_out);
  endtask

  // One instruction through REQUEST/WAIT/UPDATE. Entered and left on a
  // falling edge. g = cycles ready is held low before it is raised.
  // r = WAITING cycles before the response or ack pulse.
  task automatic run_txn(input bit en, input bit rd, input bit wr,
                         input logic [DW-1:0] a, input logic [DW-1:0] d,
                         input int g, input int r, input logic [DW-1:0] rdata);
    bit is_rd, active, timed;
    int k, kend;
    logic [1:0] es;
    active = en && (rd || wr);
    is_rd  = rd;

    core_state = 3'b011;
    enable     = en;
    rd_en      = rd;
    wr_en      = wr;
    rs         = a;
    rt         = d;
    @(negedge clk);
    // The scheduler moves on. The operands change so latching is exercised.
    core_state = 3'b100;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    rs         = DW'($urandom);
    rt         = DW'($urandom);

    if (!active) begin
      check_idle("noop_c1");
      mem_read_rsp_valid = 1'b1;
      mem_read_data      = DW'($urandom);
      mem_write_ack      = 1'b1;
      @(negedge clk);
      check_idle("noop_c2");
      quiet_inputs();
      @(negedge clk);
      check_idle("noop_c3");
      return;
    end

    // Reference model: a transaction occupies REQUESTING+WAITING for k cycles
    // unless that reaches the timeout limit first.
    k     = g + 2 + r;
    timed = (k >= TO);
    kend  = timed ? TO : k;
    exp_q.delete();
    for (int c = 1; c <= kend; c++) exp_q.push_back((c <= g + 1) ? 2'b01 : 2'b10);
    exp_q.push_back(2'b11);
    if (timed) begin
      exp_out = '0;
      exp_err = 1'b1;
    end else if (is_rd) begin
      exp_out = rdata;
    end

    for (int c = 1; exp_q.size() > 0; c++) begin
      es = exp_q.pop_front();
      chk("state", lsu_state, es);
      chk("rvalid", mem_read_valid,  (es == 2'b01) &&  is_rd);
      chk("wvalid", mem_write_valid, (es == 2'b01) && !is_rd);
      if (es == 2'b01 && is_rd)  chk("raddr", mem_read_address, a);
      if (es == 2'b01 && !is_rd) begin
        chk("waddr", mem_write_address, a);
        chk("wdata", mem_write_data, d);
      end
      mem_read_ready     = is_rd  && (c == g + 1);
      mem_write_ready    = !is_rd && (c == g + 1);
      mem_read_rsp_valid = is_rd  && (c == k);
      mem_write_ack      = !is_rd && (c == k);
      mem_read_data      = (c == k) ? rdata : DW'($urandom);
      if (es == 2'b11) begin
        chk("done_out", lsu_out, exp_out);
        chk("done_err", timeout_err, exp_err);
        // Stray responses in DONE must be ignored.
        mem_read_rsp_valid = 1'b1;
        mem_write_ack      = 1'b1;
      end
      @(negedge clk);
    end

    mem_read_rsp_valid = 1'b0;
    mem_write_ack      = 1'b0;
    mem_read_ready     = 1'b0;
    mem_write_ready    = 1'b0;
    chk("hold_state", lsu_state, 2'b11);
    chk("hold_out", lsu_out, exp_out);
    core_state = 3'b110;
    @(negedge clk);
    check_idle("upd");
    chk("upd_err", timeout_err, exp_err);
    quiet_inputs();
  endtask

  task automatic reset_mid_wait();
    core_state = 3'b011;
    enable     = 1'b1;
    rd_en      = 1'b1;
    rs         = 8'h3C;
    @(negedge clk);
    core_state     = 3'b100;
    rd_en          = 1'b0;
    mem_read_ready = 1'b1;
    @(negedge clk);
    mem_read_ready = 1'b0;
    chk("rst_pre_state", lsu_state, 2'b10);
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    exp_out = '0;
    exp_err = 1'b0;
    chk("rst_err", timeout_err, 1'b0);
    check_idle("rst_mid");
    mem_read_rsp_valid = 1'b1;
    mem_read_data      = 8'hAB;
    @(negedge clk);
    mem_read_rsp_valid = 1'b0;
    check_idle("rst_late_rsp");
    quiet_inputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit en, rd, wr;
    reset   = 1'b1;
    rs      = '0;
    rt      = '0;
    exp_out = '0;
    exp_err = 1'b0;
    quiet_inputs();
    repeat (2) @(negedge clk);
    check_idle("reset");
    chk("reset_err", timeout_err, 1'b0);
    chk("reset_raddr", mem_read_address, 8'h00);
    chk("reset_waddr", mem_write_address, 8'h00);
    chk("reset_wdata", mem_write_data, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_txn(1'b1, 1'b1, 1'b0, 8'h24, 8'h00, 0, 2, 8'h5A);   // LDR
    run_txn(1'b1, 1'b0, 1'b1, 8'h10, 8'hC3, 4, 1, 8'h00);   // STR, ready late
    run_txn(1'b0, 1'b1, 1'b0, 8'h55, 8'h66, 0, 0, 8'h11);   // enable low
    run_txn(1'b1, 1'b0, 1'b0, 8'h55, 8'h66, 0, 0, 8'h11);   // no mem op
    run_txn(1'b1, 1'b1, 1'b1, 8'h81, 8'h7E, 1, 1, 8'hE7);   // both set
    run_txn(1'b1, 1'b1, 1'b0, 8'h42, 8'h00, 20, 0, 8'h99);  // timeout in 01
    run_txn(1'b1, 1'b0, 1'b1, 8'h07, 8'h3D, 0, 0, 8'h00);   // write after timeout

    // Randomized instructions.
    for (int i = 0; i < 40; i++) begin
      en = ($urandom_range(0, 7) != 0);
      rd = $urandom_range(0, 1);
      wr = $urandom_range(0, 1);
      run_txn(en, rd, wr, DW'($urandom), DW'($urandom),
              $urandom_range(0, 4), $urandom_range(0, 4), DW'($urandom));
    end

    reset_mid_wait();
    run_txn(1'b1, 1'b1, 1'b0, 8'hF0, 8'h00, 1, 0, 8'h2D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
